// File: rtl/ps2_move_pkg.sv
// Shared definitions for the synthetic key-event player: scan codes,
// the 2-bit move encoding and the player FSM states.
package ps2_move_pkg;

  localparam logic [8:0] KEY_W = 9'h01D;
  localparam logic [8:0] KEY_A = 9'h01C;
  localparam logic [8:0] KEY_S = 9'h01B;
  localparam logic [8:0] KEY_D = 9'h023;

  typedef enum logic [1:0] {
    DIR_W = 2'd0,
    DIR_A = 2'd1,
    DIR_S = 2'd2,
    DIR_D = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_GAP  = 2'd2,
    ST_KEY  = 2'd3
  } state_t;

  function automatic logic is_move(input logic [8:0] code);
    return (code == KEY_W) || (code == KEY_A) || (code == KEY_S) || (code == KEY_D);
  endfunction

  // Non-move codes map to DIR_W; callers gate with is_move().
  function automatic dir_t code_to_dir(input logic [8:0] code);
    dir_t d;
    case (code)
      KEY_A:   d = DIR_A;
      KEY_S:   d = DIR_S;
      KEY_D:   d = DIR_D;
      default: d = DIR_W;
    endcase
    return d;
  endfunction

  function automatic logic [8:0] dir_to_code(input dir_t d);
    logic [8:0] c;
    case (d)
      DIR_A:   c = KEY_A;
      DIR_S:   c = KEY_S;
      DIR_D:   c = KEY_D;
      default: c = KEY_W;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/move_buffer.sv
// DEPTH x 2-bit move store: one write port, one read port with
// registered read data. Contents are not reset.
module move_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk_10Hz,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_data
);

  logic [1:0] mem [DEPTH];

  // Synchronous write and registered read.
  always_ff @(posedge clk_10Hz) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ps2_move_player.sv
// Records W/A/S/D key events into a move buffer and replays them as
// synthetic key events spaced STEP_TICKS clk_10Hz cycles apart.
// Optional macro PS2_MOVE_PLAYER_LOOP_EN: replay wraps to entry 0 and
// repeats until stop; undefined gives a single pass.
//
// state | meaning
// IDLE  | waiting for rec_start / play_start
// REC   | storing valid moves into the buffer
// GAP   | replay, counting down between emitted keys
// KEY   | replay, buffer[ptr] is on rd_data; event emitted next cycle
module ps2_move_player
  import ps2_move_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6,
  parameter int STEP_TICKS = 5
) (
  input  logic            clk_10Hz,
  input  logic            rst,
  input  logic            rec_start,
  input  logic            play_start,
  input  logic            stop,
  input  logic            in_valid,
  input  logic [8:0]      in_code,
  output logic            out_valid,
  output logic [8:0]      out_code,
  output logic            busy,
  output logic [ADDR_W:0] rec_len,
  output logic            overflow
);

  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TW-1:0]   T_INIT = TW'(STEP_TICKS - 1);
  localparam logic [TW-1:0]   T_LAST = TW'(1);
  localparam logic [ADDR_W:0] FULL   = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W:0]   len_d;
  logic              ovf_d;
  logic              wr_en;
  logic [1:0]        rd_data;
  logic              emit;
  logic              last_entry;

  // The read address is the next pointer, so buffer[ptr] is already on
  // rd_data during the KEY cycle.
  move_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
    .clk_10Hz (clk_10Hz),
    .wr_en    (wr_en),
    .wr_addr  (rec_len[ADDR_W-1:0]),
    .wr_data  (code_to_dir(in_code)),
    .rd_addr  (ptr_d),
    .rd_data  (rd_data)
  );

  assign emit       = (state_q == ST_KEY) && !stop;
  assign last_entry = (({1'b0, ptr_q} + 1'b1) == rec_len);

  // Next-state, pointer, timer and record bookkeeping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    len_d   = rec_len;
    ovf_d   = overflow;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (rec_start) begin
          state_d = ST_REC;
          len_d   = '0;
          ovf_d   = 1'b0;
        end else if (play_start && (rec_len != '0)) begin
          state_d = ST_KEY;
          ptr_d   = '0;
        end
      end
      ST_REC: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (rec_start) begin
          len_d = '0;
          ovf_d = 1'b0;
        end else if (in_valid && is_move(in_code)) begin
          if (rec_len == FULL) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            len_d = rec_len + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (timer_q == T_LAST) begin
          state_d = ST_KEY;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_KEY: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          timer_d = T_INIT;
          state_d = (STEP_TICKS == 1) ? ST_KEY : ST_GAP;
          if (last_entry) begin
`ifdef PS2_MOVE_PLAYER_LOOP_EN
            ptr_d = '0;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; busy follows the state being entered.
  always_ff @(posedge clk_10Hz or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      timer_q   <= '0;
      rec_len   <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      rec_len   <= len_d;
      overflow  <= ovf_d;
      out_valid <= emit;
      if (emit) out_code <= dir_to_code(dir_t'(rd_data));
      busy      <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ps2_move_player.sv
// Scoreboard bench for ps2_move_player (DEPTH=4, STEP_TICKS=5).
// Build with PS2_MOVE_PLAYER_LOOP_EN to exercise looping replay.
module tb_ps2_move_player;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int STEP   = 5;

  logic             clk_10Hz = 1'b0;
  logic             rst = 1'b1;
  logic             rec_start = 1'b0;
  logic             play_start = 1'b0;
  logic             stop = 1'b0;
  logic             in_valid = 1'b0;
  logic [8:0]       in_code = '0;
  logic             out_valid;
  logic [8:0]       out_code;
  logic             busy;
  logic [ADDR_W:0]  rec_len;
  logic             overflow;

  typedef struct {
    int         cyc;
    logic [8:0] code;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] plan[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  ps2_move_player #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STEP_TICKS(STEP)) dut (
    .clk_10Hz   (clk_10Hz),
    .rst        (rst),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_code   (out_code),
    .busy       (busy),
    .rec_len    (rec_len),
    .overflow   (overflow)
  );

  always #50 clk_10Hz = ~clk_10Hz;

  always @(posedge clk_10Hz) cyc <= cyc + 1;

  // Monitor: every emitted event must match the head of the scoreboard.
  always @(negedge clk_10Hz) begin : mon
    exp_t e;
    if (!rst && out_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: code=%h at cycle %0d, none expected", out_code, cyc);
      end else begin
        e = sb.pop_front();
        if (out_code !== e.code || cyc != e.cyc) begin
          bad++;
          $display("FAIL event: code=%h cycle=%0d, want code=%h cycle=%0d",
                   out_code, cyc, e.code, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_10Hz);
  endtask

  task automatic press(input logic [8:0] c);
    in_valid = 1'b1;
    in_code  = c;
    @(negedge clk_10Hz);
    in_valid = 1'b0;
  endtask

  task automatic do_rec();
    rec_start = 1'b1;
    @(negedge clk_10Hz);
    rec_start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk_10Hz);
    stop = 1'b0;
  endtask

  // Issue play_start; expect plan[i] STEP*i cycles after the first event,
  // which lands two cycles after the cycle play_start is driven in.
  task automatic play();
    int c0;
    exp_t e;
    c0 = cyc;
    foreach (plan[i]) begin
      e.cyc  = c0 + 2 + STEP * i;
      e.code = plan[i];
      sb.push_back(e);
    end
    play_start = 1'b1;
    @(negedge clk_10Hz);
    play_start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk_10Hz);
      #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d events pending after %0d cycles, want 0", sb.size(), budget);
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, limit 2000000");
    $fatal(1);
  end

  initial begin
    cycles(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rec_len", 32'(rec_len), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    cycles(1);

    // 1: record W,D,D,S and replay at 5-cycle spacing
    do_rec();
    chk("t1_busy_rec", 32'(busy), 32'd1);
    press(9'h01D); press(9'h023); press(9'h023); press(9'h01B);
    do_stop();
    chk("t1_rec_len", 32'(rec_len), 32'd4);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    plan = '{9'h01D, 9'h023, 9'h023, 9'h01B};
    play();
    chk("t1_busy_play", 32'(busy), 32'd1);
    drain(40);
    chk("t1_busy_after", 32'(busy), 32'd0);
    cycles(1);
    chk("t1_out_valid_low", 32'(out_valid), 32'd0);
    chk("t1_code_held", 32'(out_code), 32'h01B);

    // 2: non-move code ignored; in_valid together with stop discarded
    do_rec();
    press(9'h029); press(9'h01C); press(9'h01D); press(9'h023);
    in_valid = 1'b1; in_code = 9'h01B; stop = 1'b1;
    @(negedge clk_10Hz);
    in_valid = 1'b0; stop = 1'b0;
    chk("t2_rec_len", 32'(rec_len), 32'd3);
    plan = '{9'h01C, 9'h01D, 9'h023};
    play();
    drain(30);

    // 3: overflow with DEPTH=4, then rec_start (from REC) clears both
    do_rec();
    press(9'h01D); press(9'h01C); press(9'h01B); press(9'h023); press(9'h01D); press(9'h01C);
    chk("t3_rec_len_sat", 32'(rec_len), 32'd4);
    chk("t3_overflow", 32'(overflow), 32'd1);
    do_rec();
    chk("t3_rec_len_clr", 32'(rec_len), 32'd0);
    chk("t3_overflow_clr", 32'(overflow), 32'd0);
    do_stop();

    // 4: play_start with empty buffer does nothing
    play_start = 1'b1;
    @(negedge clk_10Hz);
    play_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t4_busy", 32'(busy), 32'd0);
      @(negedge clk_10Hz);
    end

    // 5: stop during GAP after second key; replay restarts at entry 0
    do_rec();
    press(9'h01D); press(9'h01C); press(9'h01B); press(9'h023);
    do_stop();
    plan = '{9'h01D, 9'h01C};
    play();
    drain(20);
    do_stop();
    chk("t5_busy_after_stop", 32'(busy), 32'd0);
    cycles(25);
    plan = '{9'h01D, 9'h01C, 9'h01B, 9'h023};
    play();
    drain(40);

    // 6: asynchronous reset while an event is on the outputs
    plan = '{9'h01D};
    play();
    drain(10);
    rst = 1'b1;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_out_code", 32'(out_code), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rec_len", 32'(rec_len), 32'd0);
    @(negedge clk_10Hz);
    rst = 1'b0;
    cycles(15);
    chk("t6_busy_idle", 32'(busy), 32'd0);

    // A,D replay: loops until stop when looping is built in
    do_rec();
    press(9'h01C); press(9'h023);
    do_stop();
`ifdef PS2_MOVE_PLAYER_LOOP_EN
    plan = '{9'h01C, 9'h023, 9'h01C, 9'h023, 9'h01C, 9'h023};
`else
    plan = '{9'h01C, 9'h023};
`endif
    play();
    drain(50);
    do_stop();
    chk("loop_busy_after_stop", 32'(busy), 32'd0);
    cycles(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
